regfile_scoreboard: RTL

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard.sv | 82 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard: tracks in-flight writes per architectural register
// and stalls decode on RAW hazards or when a register's pending-write counter is full.
module regfile_scoreboard #(
  parameter int CNT_W = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       issue_valid,
  input  logic [4:0] issue_rs1,
  input  logic [4:0] issue_rs2,
  input  logic       issue_rs1_used,
  input  logic       issue_rs2_used,
  input  logic [4:0] issue_rd,
  input  logic       issue_rd_we,
  input  logic       wb_valid,
  input  logic [4:0] wb_rd,
  input  logic       flush,
  output logic       stall,
  output logic       issue_accept,
  output logic       busy,
  output logic       err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Entry 0 is never written, so it always reads as zero.
  logic [CNT_W-1:0] cnt     [32];
  logic [CNT_W-1:0] cnt_nxt [32];

  logic [CNT_W-1:0] c_rs1, c_rs2, c_rd, c_wb;
  logic             rs1_haz, rs2_haz, full_haz;
  logic             inc, dec, err_set, busy_nxt;

  assign c_rs1 = cnt[issue_rs1];
  assign c_rs2 = cnt[issue_rs2];
  assign c_rd  = cnt[issue_rd];
  assign c_wb  = cnt[wb_rd];

  // A retiring last write is forwarded through the regfile in the same cycle.
  assign rs1_haz = issue_rs1_used && (issue_rs1 != 5'd0) && (c_rs1 != '0) &&
                   !(wb_valid && (wb_rd == issue_rs1) && (c_rs1 == CNT_ONE));
  assign rs2_haz = issue_rs2_used && (issue_rs2 != 5'd0) && (c_rs2 != '0) &&
                   !(wb_valid && (wb_rd == issue_rs2) && (c_rs2 == CNT_ONE));
  assign full_haz = issue_rd_we && (issue_rd != 5'd0) && (c_rd == CNT_MAX) &&
                    !(wb_valid && (wb_rd == issue_rd));

  assign stall        = issue_valid && !flush && (rs1_haz || rs2_haz || full_haz);
  assign issue_accept = issue_valid && !stall && !flush;

  assign inc     = issue_accept && issue_rd_we && (issue_rd != 5'd0);
  assign dec     = wb_valid && (wb_rd != 5'd0) && (c_wb != '0) && !flush;
  assign err_set = wb_valid && (wb_rd != 5'd0) && (c_wb == '0) && !flush;

  always_comb begin
    cnt_nxt  = cnt;
    busy_nxt = 1'b0;
    for (int i = 1; i < 32; i++) begin
      if (flush) begin
        cnt_nxt[i] = '0;
      end else if (inc && (issue_rd == 5'(i)) && !(dec && (wb_rd == 5'(i)))) begin
        cnt_nxt[i] = cnt[i] + CNT_ONE;
      end else if (dec && (wb_rd == 5'(i)) && !(inc && (issue_rd == 5'(i)))) begin
        cnt_nxt[i] = cnt[i] - CNT_ONE;
      end
      busy_nxt = busy_nxt | (cnt_nxt[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
      busy <= 1'b0;
      err  <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
      busy <= busy_nxt;
      err  <= err | err_set;
    end
  end

endmodule
